ifetch: RTL and testbench



---
 rtl/ifetch.sv | 160 ++++++++++++++++
 tb/tb_ifetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch stage
//
// Owns the program counter and drives a synchronous instruction RAM that has a
// one-cycle read latency. A two-entry buffer absorbs that latency and presents
// a valid/ready instruction stream to decode. A branch redirect from decode
// squashes every wrong-path fetch and resumes fetching at the target.
//
// Parameters
//   RESET_PC       byte address fetched first after reset (bits [1:0] = 0)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   imem_addr      byte address to instruction RAM (RAM uses [31:2])
//   imem_rdata     RAM read data, valid the cycle after imem_addr
//   dec_instr      instruction at buffer head (zero when empty)
//   dec_pc         byte address of dec_instr (zero when empty)
//   dec_valid      buffer head holds a valid instruction
//   dec_ready      decode accepts the head this cycle
//   link_addr      dec_pc + 4, return address for branch-with-link
//   br_taken       single-cycle redirect request from decode
//   br_target      redirect byte address, [1:0] forced to 0
//
// Optional build macro IFETCH_PERF_EN adds:
//   perf_fetched   count of instructions popped by decode (wraps)
//   perf_squashed  count of buffered + in-flight fetches discarded by redirects
// ----------------------------------------------------------------------------
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] link_addr,
   input  logic        br_taken,
   input  logic [31:0] br_target
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
   logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;

   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occ;        // entries that will still be owed a slot after this edge
   logic [1:0]  count_tmp;

   assign imem_addr = fetch_pc_q;
   assign dec_valid = (count_q != 2'd0);
   assign dec_instr = dec_valid ? instr0_q : 32'h0;
   assign dec_pc    = dec_valid ? pc0_q    : 32'h0;
   assign link_addr = dec_pc + 32'd4;

   always_comb begin
      pop   = dec_valid && dec_ready;
      // Credit rule: buffered + in-flight - leaving must stay below 2 to issue,
      // so a returning word always has a slot. pop implies count_q >= 1, so no
      // underflow.
      occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue = (occ < 3'd2) && !br_taken;
      push  = inflight_q && !br_taken;

      instr0_d      = instr0_q;
      instr1_d      = instr1_q;
      pc0_d         = pc0_q;
      pc1_d         = pc1_q;
      inflight_pc_d = inflight_pc_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      count_tmp     = count_q;

      // Pop shifts entry 1 into the head, then the push lands in the first
      // free slot of the post-pop buffer.
      if (pop) begin
         instr0_d  = instr1_q;
         pc0_d     = pc1_q;
         count_tmp = count_q - 2'd1;
      end
      if (push) begin
         if (count_tmp == 2'd0) begin
            instr0_d = imem_rdata;
            pc0_d    = inflight_pc_q;
         end else begin
            instr1_d = imem_rdata;
            pc1_d    = inflight_pc_q;
         end
         count_tmp = count_tmp + 2'd1;
      end

      // A redirect keeps the popped branch but drops everything behind it,
      // including the word returning from RAM this edge.
      count_d = br_taken ? 2'd0 : count_tmp;

      if (br_taken) begin
         fetch_pc_d = br_target & ~32'd3;
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   // Payload registers need no reset: outputs are masked while count is 0.
   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
      instr0_q      <= instr0_d;
      instr1_q      <= instr1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_squashed_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q  <= 32'h0;
         perf_squashed_q <= 32'h0;
      end else begin
         perf_fetched_q <= perf_fetched_q + {31'h0, pop};
         // occ is exactly what a redirect throws away: survivors of the pop
         // plus the in-flight return.
         if (br_taken) begin
            perf_squashed_q <= perf_squashed_q + {29'h0, occ};
         end
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- bench for ifetch
//
// Instance A (RESET_PC 0x100) runs the main scenarios; instance B
// (RESET_PC 0xFFFF_FFF8) checks PC wrap-around. A negedge monitor keeps a
// queue of expected PCs (refilled on reset and on redirect) and compares each
// handshake against its head. Build with +define+IFETCH_PERF_EN to include
// the counter checks.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch;

   localparam logic [31:0] RPC_A = 32'h0000_0100;
   localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

   logic        clk;
   logic        reset;

   logic [31:0] imem_addr_a, imem_rdata_a, dec_instr_a, dec_pc_a, link_addr_a, br_target_a;
   logic        dec_valid_a, dec_ready_a, br_taken_a;
   logic [31:0] imem_addr_b, imem_rdata_b, dec_instr_b, dec_pc_b, link_addr_b;
   logic        dec_valid_b;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_a, perf_squashed_a, perf_fetched_b, perf_squashed_b;
`endif

   int checks;
   int errors;
   int pops_a;
   logic [31:0] exp_q[$];

   ifetch #(.RESET_PC(RPC_A)) u_dut_a (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
      .dec_instr(dec_instr_a), .dec_pc(dec_pc_a), .dec_valid(dec_valid_a),
      .dec_ready(dec_ready_a), .link_addr(link_addr_a),
      .br_taken(br_taken_a), .br_target(br_target_a)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched_a), .perf_squashed(perf_squashed_a)
`endif
   );

   ifetch #(.RESET_PC(RPC_B)) u_dut_b (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
      .dec_instr(dec_instr_b), .dec_pc(dec_pc_b), .dec_valid(dec_valid_b),
      .dec_ready(1'b1), .link_addr(link_addr_b),
      .br_taken(1'b0), .br_target(32'h0)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched_b), .perf_squashed(perf_squashed_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAMs: word n holds 0xA000_0000 + n.
   always @(posedge clk) begin
      imem_rdata_a <= 32'hA000_0000 + {2'b00, imem_addr_a[31:2]};
      imem_rdata_b <= 32'hA000_0000 + {2'b00, imem_addr_b[31:2]};
   end

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'hA000_0000 + {2'b00, pc[31:2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic refill(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: handshakes are decided by values stable at negedge.
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset) begin
         refill(RPC_A);
         pops_a = 0;
      end else begin
         if (dec_valid_a && dec_ready_a) begin
            pops_a++;
            if (exp_q.size() == 0) begin
               check("sb_empty", dec_pc_a, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", dec_pc_a, e);
               check("sb_instr", dec_instr_a, word_of(e));
               check("sb_link", link_addr_a, e + 32'd4);
            end
         end
         if (br_taken_a) refill(br_target_a & ~32'd3);
         // A push into a full buffer without a simultaneous pop loses data.
         if (u_dut_a.inflight_q && !br_taken_a && u_dut_a.count_q == 2'd2
             && !(dec_valid_a && dec_ready_a)) begin
            errors++;
            $display("FAIL overflow push with count=2");
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      pops_a = 0;
      reset = 1'b1;
      dec_ready_a = 1'b1;
      br_taken_a = 1'b0;
      br_target_a = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_addr", imem_addr_a, RPC_A);
      check("rst_valid", {31'h0, dec_valid_a}, 32'h0);
      check("rst_instr", dec_instr_a, 32'h0);
      check("rst_pc", dec_pc_a, 32'h0);
      check("rst_link", link_addr_a, 32'h4);
      check("rst_addr_b", imem_addr_b, RPC_B);
`ifdef IFETCH_PERF_EN
      check("rst_pf", perf_fetched_a, 32'h0);
      check("rst_ps", perf_squashed_a, 32'h0);
`endif

      // Cycle 0 starts at deassert.
      reset = 1'b0;
      check("c0_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("c1_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("c2_valid", {31'h0, dec_valid_a}, 32'h1);
      check("c2_pc", dec_pc_a, 32'h100);
      check("c2_pc_b", dec_pc_b, 32'hFFFF_FFF8);
      check("c2_valid_b", {31'h0, dec_valid_b}, 32'h1);

      // Stall for 5 cycles starting at the first valid cycle.
      dec_ready_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         check("stall_addr", imem_addr_a, 32'h108);
         check("stall_pc", dec_pc_a, 32'h100);
         check("stall_instr", dec_instr_a, word_of(32'h100));
         check("stall_valid", {31'h0, dec_valid_a}, 32'h1);
         if (i == 0) begin
            check("wrap_pc1", dec_pc_b, 32'hFFFF_FFFC);
            check("wrap_link", link_addr_b, 32'h0);
         end
         if (i == 1) begin
            check("wrap_pc2", dec_pc_b, 32'h0);
            check("wrap_instr", dec_instr_b, 32'hA000_0000);
         end
      end

      // Release: back-to-back delivery with no gap.
      dec_ready_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rel_valid", {31'h0, dec_valid_a}, 32'h1);
         check("rel_pc", dec_pc_a, 32'h100 + 32'(4 * i));
         if (i < 3) tick;
      end
      // Head is 0x10C: stop accepting so the buffer fills to 2.
      dec_ready_a = 1'b0;
      tick;
      check("full_pc", dec_pc_a, 32'h10C);

      // Redirect with a full buffer and no pop.
      br_taken_a = 1'b1;
      br_target_a = 32'h203;
      tick;
      br_taken_a = 1'b0;
      dec_ready_a = 1'b1;
      check("r1_n1_addr", imem_addr_a, 32'h200);
      check("r1_n1_valid", {31'h0, dec_valid_a}, 32'h0);
`ifdef IFETCH_PERF_EN
      check("r1_squash", perf_squashed_a, 32'd2);
`endif
      tick;
      check("r1_n2_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("r1_n3_valid", {31'h0, dec_valid_a}, 32'h1);
      check("r1_n3_pc", dec_pc_a, 32'h200);
      check("r1_n3_instr", dec_instr_a, word_of(32'h200));
      tick;
      tick;
      tick;
      check("r2_branch_pc", dec_pc_a, 32'h20C);

      // Redirect in the same cycle the branch is popped.
      br_taken_a = 1'b1;
      br_target_a = 32'h400;
      tick;
      br_taken_a = 1'b0;
      check("r2_n1_addr", imem_addr_a, 32'h400);
      check("r2_n1_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("r2_n2_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("r2_n3_pc", dec_pc_a, 32'h400);
      check("r2_n3_instr", dec_instr_a, word_of(32'h400));
`ifdef IFETCH_PERF_EN
      check("r2_fetched", perf_fetched_a, 32'(pops_a));
      check("r2_squash", perf_squashed_a, 32'd3);
`endif
      tick;
      tick;

      // Asynchronous reset mid-stream, overriding a redirect.
      br_taken_a = 1'b1;
      br_target_a = 32'h800;
      #1;
      reset = 1'b1;
      #1;
      check("mr_valid", {31'h0, dec_valid_a}, 32'h0);
      check("mr_addr", imem_addr_a, RPC_A);
      check("mr_pc", dec_pc_a, 32'h0);
      check("mr_link", link_addr_a, 32'h4);
`ifdef IFETCH_PERF_EN
      check("mr_pf", perf_fetched_a, 32'h0);
`endif
      tick;
      check("mr_hold_addr", imem_addr_a, RPC_A);
      reset = 1'b0;
      br_taken_a = 1'b0;
      check("mr_c0_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("mr_c1_valid", {31'h0, dec_valid_a}, 32'h0);
      tick;
      check("mr_c2_valid", {31'h0, dec_valid_a}, 32'h1);
      check("mr_c2_pc", dec_pc_a, RPC_A);
      repeat (4) tick;
      check("mr_c6_pc", dec_pc_a, RPC_A + 32'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
